// File: rtl/term_pkg.sv
// Shared constants and state encoding for the terminal byte path.
// Geometry is shared with the cursor position controller.
package term_pkg;

    localparam int COLS  = 60;
    localparam int ROWS  = 17;
    localparam int CELLS = COLS * ROWS;

    localparam int AW = 10;
    localparam int RW = 5;
    localparam int CW = 6;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_NL_PULSE,
        ST_NL_WAIT,
        ST_CLR,
        ST_HOME
    } state_e;

endpackage

// File: rtl/term_ctrl_if.sv
// Byte/cursor/text-RAM bundle of the terminal control stage.
// master: the control stage; slave: its environment.
interface term_ctrl_if;
    import term_pkg::*;

    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic [RW-1:0] i_row;
    logic [CW-1:0] i_col;
    logic          o_ready;
    logic          o_overrun;
    logic          o_cmd_home;
    logic          o_cmd_advance;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [7:0]    o_wr_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_row, i_col,
        output o_ready, o_overrun, o_cmd_home, o_cmd_advance,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_row, i_col,
        input  o_ready, o_overrun, o_cmd_home, o_cmd_advance,
        input  o_wr_en, o_wr_addr, o_wr_data
    );

endinterface

// File: rtl/cell_addr.sv
// Row/column to linear text RAM address (row*COLS+col).
// Shared with the VGA read-side text fetch.
module cell_addr
    import term_pkg::*;
(
    input  logic [RW-1:0] i_row,
    input  logic [CW-1:0] i_col,
    output logic [AW-1:0] o_addr
);

    // Max result is 1019, so 10-bit arithmetic never wraps.
    assign o_addr = AW'(i_row) * AW'(COLS) + AW'(i_col);

endmodule

// File: rtl/term_ctrl.sv
// Terminal byte control: prints characters, handles LF and FF,
// and drives home/advance commands to the position controller.
module term_ctrl
    import term_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    term_ctrl_if.master bus
);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          ovr_q, ovr_d;
    logic          home_q, home_d;
    logic          adv_q, adv_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [AW-1:0] cur_addr;
    logic          is_print, is_lf, is_ff;

    cell_addr u_cell_addr (
        .i_row  (bus.i_row),
        .i_col  (bus.i_col),
        .o_addr (cur_addr)
    );

    assign is_print = (bus.i_rx_data >= CH_BLANK) &&
                      (bus.i_rx_data <  CH_DEL);
    assign is_lf    = (bus.i_rx_data == CH_LF);
    assign is_ff    = (bus.i_rx_data == CH_FF);

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        home_d    = 1'b0;
        adv_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovr_d     = ovr_q | (bus.i_rx_valid & ~ready_q);
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    unique case (1'b1)
                        is_print: begin
                            state_d   = ST_PUT;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cur_addr;
                            wr_data_d = bus.i_rx_data;
                            adv_d     = 1'b1;
                        end
                        is_lf: begin
                            state_d = ST_NL_PULSE;
                            adv_d   = 1'b1;
                        end
                        is_ff: begin
                            state_d   = ST_CLR;
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = CH_BLANK;
                        end
                        default: ;
                    endcase
                end
            end
            ST_PUT:      state_d = ST_IDLE;
            ST_NL_PULSE: state_d = ST_NL_WAIT;
            ST_NL_WAIT: begin
                // Cursor wrapped to column 0: the line is done.
                if (bus.i_col == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_NL_PULSE;
                    adv_d   = 1'b1;
                end
            end
            ST_CLR: begin
                // The write address doubles as the sweep counter.
                if (wr_addr_q == AW'(CELLS - 1)) begin
                    state_d = ST_HOME;
                    home_d  = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = CH_BLANK;
                end
            end
            ST_HOME: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            ovr_q     <= 1'b0;
            home_q    <= 1'b0;
            adv_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            home_q    <= home_d;
            adv_q     <= adv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_overrun     = ovr_q;
    assign bus.o_cmd_home    = home_q;
    assign bus.o_cmd_advance = adv_q;
    assign bus.o_wr_en       = wr_en_q;
    assign bus.o_wr_addr     = wr_addr_q;
    assign bus.o_wr_data     = wr_data_q;

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: cycle-indexed expectation model plus
// directed vectors with hand-computed values.
module tb_term_ctrl;

    localparam int NC = 60;
    localparam int NR = 17;
    localparam int NCELL = 1020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    bit   in_rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    term_ctrl_if bus();

    term_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Position controller stand-in.
    logic [4:0] pos_row = '0;
    logic [5:0] pos_col = '0;
    bit         ld = 1'b0;
    logic [4:0] ld_r;
    logic [5:0] ld_c;

    assign bus.i_row = pos_row;
    assign bus.i_col = pos_col;

    always @(posedge clk) begin
        if (ld) begin
            pos_row <= ld_r;
            pos_col <= ld_c;
        end else if (bus.o_cmd_home) begin
            pos_row <= '0;
            pos_col <= '0;
        end else if (bus.o_cmd_advance) begin
            if (int'(pos_col) == NC - 1) begin
                pos_col <= '0;
                if (int'(pos_row) != NR - 1) pos_row <= pos_row + 1'b1;
            end else begin
                pos_col <= pos_col + 1'b1;
            end
        end
    end

    // Expectation model, indexed by cycle number.
    bit exp_wr[int];
    int exp_addr[int];
    int exp_data[int];
    bit exp_adv[int];
    bit exp_home[int];
    int busy_start = 0;
    int busy_until = 0;
    int ovr_from = 1 << 30;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                         nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        exp_wr.delete();
        exp_addr.delete();
        exp_data.delete();
        exp_adv.delete();
        exp_home.delete();
        busy_start = 0;
        busy_until = 0;
        ovr_from = 1 << 30;
    endfunction

    function automatic void model_send(logic [7:0] b, int t);
        int n;
        if (t >= busy_start && t < busy_until) begin
            if (ovr_from > t + 1) ovr_from = t + 1;
            return;
        end
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_wr[t+1] = 1'b1;
            exp_addr[t+1] = int'(pos_row) * NC + int'(pos_col);
            exp_data[t+1] = int'(b);
            exp_adv[t+1] = 1'b1;
            busy_start = t + 1;
            busy_until = t + 2;
        end else if (b == 8'h0A) begin
            n = NC - int'(pos_col);
            for (int i = 0; i < n; i++) exp_adv[t+1+2*i] = 1'b1;
            busy_start = t + 1;
            busy_until = t + 1 + 2 * n;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < NCELL; i++) begin
                exp_wr[t+1+i] = 1'b1;
                exp_addr[t+1+i] = i;
                exp_data[t+1+i] = 32'h20;
            end
            exp_home[t+1+NCELL] = 1'b1;
            busy_start = t + 1;
            busy_until = t + 2 + NCELL;
        end
    endfunction

    // Observers for directed checks.
    int wr_cnt = 0;
    int adv_cnt = 0;
    int home_cnt = 0;
    int last_addr = 0;
    int last_data = 0;
    bit ew;

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!in_rst) begin
            ew = exp_wr.exists(cyc);
            chk("wr_en", int'(bus.o_wr_en), int'(ew));
            if (ew) begin
                chk("wr_addr", int'(bus.o_wr_addr), exp_addr[cyc]);
                chk("wr_data", int'(bus.o_wr_data), exp_data[cyc]);
            end
            chk("advance", int'(bus.o_cmd_advance),
                int'(exp_adv.exists(cyc)));
            chk("home", int'(bus.o_cmd_home),
                int'(exp_home.exists(cyc)));
            chk("ready", int'(bus.o_ready),
                int'(!(cyc >= busy_start && cyc < busy_until)));
            chk("overrun", int'(bus.o_overrun), int'(cyc >= ovr_from));
        end
        if (bus.o_wr_en) begin
            wr_cnt++;
            last_addr = int'(bus.o_wr_addr);
            last_data = int'(bus.o_wr_data);
        end
        if (bus.o_cmd_advance) adv_cnt++;
        if (bus.o_cmd_home) home_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_valid = 1'b1;
        model_send(b, cyc);
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic set_cursor(int r, int c);
        ld = 1'b1;
        ld_r = 5'(r);
        ld_c = 6'(c);
        tick();
        ld = 1'b0;
    endtask

    task automatic wait_ready(int limit, output int t);
        int n = 0;
        while (!bus.o_ready && n < limit) begin
            tick();
            n++;
        end
        if (!bus.o_ready) chk("ready_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_wr_en"}, int'(bus.o_wr_en), 0);
        chk({tag, "_wr_addr"}, int'(bus.o_wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.o_wr_data), 0);
        chk({tag, "_adv"}, int'(bus.o_cmd_advance), 0);
        chk({tag, "_home"}, int'(bus.o_cmd_home), 0);
        chk({tag, "_ready"}, int'(bus.o_ready), 1);
        chk({tag, "_overrun"}, int'(bus.o_overrun), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, w0, a0, h0;
        bus.i_rx_data = '0;
        bus.i_rx_valid = 1'b0;
        tick();
        tick();
        chk_reset_outs("rst");
        rst_n = 1'b1;
        model_reset();
        in_rst = 1'b0;
        tick();

        // 'A' at (0,0)
        set_cursor(0, 0);
        w0 = wr_cnt; a0 = adv_cnt; t0 = cyc;
        send(8'h41);
        wait_ready(10, t1);
        chk("A_writes", wr_cnt - w0, 1);
        chk("A_addr", last_addr, 0);
        chk("A_data", last_data, 8'h41);
        chk("A_adv", adv_cnt - a0, 1);
        chk("A_ready_at", t1 - t0, 2);

        // 'z' at (2,59) wraps cursor
        set_cursor(2, 59);
        w0 = wr_cnt;
        send(8'h7A);
        wait_ready(10, t1);
        chk("z_writes", wr_cnt - w0, 1);
        chk("z_addr", last_addr, 179);
        chk("z_data", last_data, 8'h7A);
        chk("z_row", int'(pos_row), 3);
        chk("z_col", int'(pos_col), 0);

        // back-to-back printables at max rate
        set_cursor(7, 5);
        send(8'h70);
        tick();
        w0 = wr_cnt;
        send(8'h71);
        wait_ready(10, t1);
        chk("q_addr", last_addr, 7 * 60 + 6);
        chk("q_writes", wr_cnt - w0, 1);

        // LF at column 0
        set_cursor(5, 0);
        a0 = adv_cnt; t0 = cyc;
        send(8'h0A);
        wait_ready(300, t1);
        chk("lf0_adv", adv_cnt - a0, 60);
        chk("lf0_ready_at", t1 - t0, 121);
        chk("lf0_row", int'(pos_row), 6);

        // LF at column 59
        set_cursor(4, 59);
        a0 = adv_cnt; t0 = cyc;
        send(8'h0A);
        wait_ready(20, t1);
        chk("lf59_adv", adv_cnt - a0, 1);
        chk("lf59_ready_at", t1 - t0, 3);

        // LF on the last row holds the row
        set_cursor(16, 10);
        a0 = adv_cnt;
        send(8'h0A);
        wait_ready(300, t1);
        chk("lflast_adv", adv_cnt - a0, 50);
        chk("lflast_row", int'(pos_row), 16);

        // ignored bytes
        w0 = wr_cnt; a0 = adv_cnt;
        send(8'h0D);
        send(8'h7F);
        send(8'h01);
        tick();
        tick();
        chk("ign_writes", wr_cnt - w0, 0);
        chk("ign_adv", adv_cnt - a0, 0);
        chk("ign_ready", int'(bus.o_ready), 1);
        chk("ign_overrun", int'(bus.o_overrun), 0);

        // full clear with bytes dropped mid-sweep
        set_cursor(9, 33);
        w0 = wr_cnt; h0 = home_cnt; t0 = cyc;
        send(8'h0C);
        repeat (100) tick();
        send(8'h42);
        send(8'h0A);
        wait_ready(1200, t1);
        chk("ff_writes", wr_cnt - w0, 1020);
        chk("ff_last_addr", last_addr, 1019);
        chk("ff_last_data", last_data, 8'h20);
        chk("ff_home", home_cnt - h0, 1);
        chk("ff_ready_at", t1 - t0, 1022);
        chk("ff_overrun", int'(bus.o_overrun), 1);
        chk("ff_row", int'(pos_row), 0);
        chk("ff_col", int'(pos_col), 0);

        // reset at the 500th clear write
        send(8'h0C);
        repeat (499) tick();
        chk("mid_wr_en", int'(bus.o_wr_en), 1);
        chk("mid_addr", int'(bus.o_wr_addr), 499);
        @(negedge clk);
        #1;
        in_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async");
        tick();
        model_reset();
        rst_n = 1'b1;
        in_rst = 1'b0;
        tick();
        chk("post_ready", int'(bus.o_ready), 1);
        chk("post_overrun", int'(bus.o_overrun), 0);

        set_cursor(1, 1);
        w0 = wr_cnt;
        send(8'h21);
        wait_ready(10, t1);
        chk("post_writes", wr_cnt - w0, 1);
        chk("post_addr", last_addr, 61);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/term_ctrl.md
# term_ctrl

Byte-level control stage of the serial terminal, directly upstream of the cursor position controller. It takes received UART bytes and writes printable characters into text RAM at the current cursor cell. It also interprets line feed and form feed, and drives the position controller's home and advance commands. The current cursor position is read back from the position controller's row and column outputs.

## Interface
Parameters:
- COLS, 60, characters per row; the last column index is COLS-1.
- ROWS, 17, number of rows; the last row index is ROWS-1.
- CELLS, COLS*ROWS = 1020, text RAM depth.
- BLANK, 8'h20, fill character used by clear.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid on this cycle.
- i_row  in  5  current cursor row, from the position controller.
- i_col  in  6  current cursor column, from the position controller.
- o_ready  out  1  high when a byte can be accepted.
- o_overrun  out  1  sticky; set when i_rx_valid arrives while o_ready=0.
- o_cmd_home  out  1  one-cycle pulse to the position controller.
- o_cmd_advance  out  1  one-cycle pulse to the position controller.
- o_wr_en  out  1  text RAM write strobe.
- o_wr_addr  out  10  text RAM address.
- o_wr_data  out  8  text RAM data.

## Operation
- FSM states: IDLE, PUT, NL_PULSE, NL_WAIT, CLR, HOME.
- All outputs are registered. Reset values: FSM in IDLE, o_ready=1, every other output 0.
- A byte is accepted when i_rx_valid=1 and o_ready=1.
  - A byte with o_ready=0 is dropped and sets o_overrun. There is no backpressure.
  - o_overrun clears only on reset.
- Decoding of an accepted byte:
  - 0x20–0x7E goes to PUT.
  - 0x0A (LF) goes to NL_PULSE.
  - 0x0C (FF) goes to CLR with the sweep counter set to 0.
  - Any other byte, including CR and 0x7F, is ignored; the FSM stays in IDLE and o_ready stays 1.
- PUT: o_wr_en=1, o_wr_data=byte, o_wr_addr=i_row*COLS+i_col, o_cmd_advance=1. Row and column are sampled on the accept cycle. Next state is IDLE.
- LF:
  - NL_PULSE: o_cmd_advance=1, then go to NL_WAIT.
  - NL_WAIT: if i_col==0, go to IDLE; otherwise go back to NL_PULSE.
  - At least one advance is always issued, so LF at column 0 moves a full line.
  - At the last row the position controller holds the row. There is no scrolling.
- CLR: one write per cycle, o_wr_addr = counter (0..CELLS-1), o_wr_data=BLANK. After address CELLS-1, go to HOME.
- HOME: o_cmd_home=1, then go to IDLE.
- Address arithmetic: i_row*COLS+i_col computed at 10 bits. The maximum value is 1019, so there is no overflow.
- Reset during any state aborts the operation immediately. A partial clear leaves the RAM contents undefined.

## Timing
- o_ready=0 in every state except IDLE. It rises on the cycle the FSM re-enters IDLE.
- Printable byte accepted at cycle T:
  - At T+1: write strobe and advance pulse.
  - At T+2: o_ready=1. Maximum throughput is one character per 2 cycles.
  - The position updates at the end of T+1, so a byte accepted at T+2 sees the new cursor.
- LF accepted at cycle T, cursor at column c:
  - 60−c advance pulses, on cycles T+1, T+3, ….
  - o_ready at T+1+2*(60−c). Examples: c=59 gives T+3; c=0 gives T+121.
- FF accepted at cycle T:
  - Writes on T+1..T+1020.
  - o_cmd_home at T+1021.
  - o_ready at T+1022.
- o_cmd_home and o_cmd_advance are never high on the same cycle. o_wr_en is high only in PUT and CLR.

## Structure
- Shared package term_pkg holds:
  - COLS, ROWS, CELLS.
  - Character constants: CH_LF=8'h0A, CH_FF=8'h0C, CH_BLANK=8'h20, CH_DEL=8'h7F.
  - The FSM state encoding.
- The position controller imports the same COLS/ROWS constants, so its last column and last row always match this block.
- One natural sub-module: cell_addr, a combinational row*COLS+col mapping into a 10-bit address. It is reused by the VGA read-side text fetch.

## Test plan
- Reset, then 'A' (0x41) at row 0, col 0 → one write, addr 0, data 0x41; one advance pulse; o_ready low for exactly 1 cycle.
- Cursor at row 2, col 59, send 'z' → write addr 179, data 0x7A; one advance; the position model wraps to row 3, col 0.
- LF at col 0 → exactly 60 advance pulses, 2 cycles apart, and o_ready returns after 121 cycles. LF at col 59 → 1 pulse and o_ready after 3 cycles.
- FF → 1020 consecutive writes (addr 0..1019, data 0x20), then one home pulse. Extra bytes sent mid-clear are dropped and o_overrun=1.
- 0x0D, 0x7F, 0x01 → no writes, no pulses, o_ready stays 1.
- Assert i_rst_n low at the 500th clear write → all outputs 0 asynchronously. After release: IDLE, o_ready=1, o_overrun=0.
